// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
//
// In-order retirement stage fed by the reorder buffer's commit port. Accepts at
// most one completed head entry per cycle, writes its result to the integer or
// float architectural register file and returns the entry's tag so the
// register-status table can release a matching busy bit. CDB-reported
// exceptions are tracked per ROB slot; retiring a faulting entry suppresses
// its write, pulses `clear` and spends FLUSH_CYCLES cycles in FLUSH.
//
// Optional feature macro: COMMIT_PERF_EN (retire / flush performance counters).
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   i_valid/i_ready    commit handshake, i_commit_data is the ROB head entry
//   cdb_valid,
//   cdb_exception, cdb CDB broadcast {rsv_id, data} plus its fault flag
//   rf_we/rf_float/
//   rf_addr/rf_data/
//   rf_tag             registered architectural register write port and tag
//   clear              one-cycle flush pulse to ROB, stations and fetch
//   exc_cause/
//   exc_opcode         content/opcode of the last faulting entry
//   perf_retired/
//   perf_flushes       performance counters (zero without COMMIT_PERF_EN)
// -----------------------------------------------------------------------------

package commit_pkg;
  localparam int DATA_W       = 32;
  localparam int INSTR_W      = 32;
  localparam int REG_ADDR_W   = 6;
  localparam int N_ROB_W      = 3;
  localparam int N_STATIONS_W = 4;
  localparam int RSV_ID_W     = 4;
  localparam int CDB_W        = DATA_W + RSV_ID_W;

  typedef struct packed {
    logic [N_STATIONS_W-1:0] station_id;
    logic [REG_ADDR_W-1:0]   dst_reg;
    logic [INSTR_W-1:0]      opcode;
    logic [DATA_W-1:0]       content;
  } station_t;
endpackage

module commit_unit
  import commit_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 4,
  parameter int REG_FLOAT_BIT = REG_ADDR_W - 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    i_valid,
  input  station_t                i_commit_data,
  output logic                    i_ready,
  input  logic                    cdb_valid,
  input  logic                    cdb_exception,
  input  logic [CDB_W-1:0]        cdb,
  output logic                    rf_we,
  output logic                    rf_float,
  output logic [REG_ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]       rf_data,
  output logic [N_STATIONS_W-1:0] rf_tag,
  output logic                    clear,
  output logic [DATA_W-1:0]       exc_cause,
  output logic [INSTR_W-1:0]      exc_opcode,
  output logic [31:0]             perf_retired,
  output logic [15:0]             perf_flushes
);

  localparam int N_SLOTS = 2 ** N_ROB_W;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [N_SLOTS-1:0] SLOT_ONE = {{(N_SLOTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              fcnt_q, fcnt_d;
  logic [N_SLOTS-1:0]      exc_pend_q, exc_pend_d;
  logic                    rf_we_q, rf_we_d;
  logic                    rf_float_q, rf_float_d;
  logic [REG_ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]       rf_data_q, rf_data_d;
  logic [N_STATIONS_W-1:0] rf_tag_q, rf_tag_d;
  logic                    clear_q, clear_d;
  logic [DATA_W-1:0]       exc_cause_q, exc_cause_d;
  logic [INSTR_W-1:0]      exc_opcode_q, exc_opcode_d;

  logic                    retire_s;
  logic [N_ROB_W-1:0]      ret_slot_s;
  logic [RSV_ID_W-1:0]     cdb_id_s;
  logic [N_SLOTS-1:0]      set_vec_s;
  logic [N_SLOTS-1:0]      clr_vec_s;
  logic                    pend_hit_s;
  logic                    unused_s;

  // Ready depends on state only, so there is no path from i_valid.
  assign i_ready    = (state_q == ST_RUN);
  assign retire_s   = i_valid && i_ready;
  assign ret_slot_s = i_commit_data.station_id[N_ROB_W-1:0];
  assign cdb_id_s   = cdb[DATA_W +: RSV_ID_W];
  assign pend_hit_s = exc_pend_q[ret_slot_s];

  // CDB data and the id bits above the ROB slot range are not needed here.
  assign unused_s = ^{cdb[DATA_W-1:0], cdb_id_s[RSV_ID_W-1:N_ROB_W]};

  // Per-slot set/clear masks for the exception vector.
  always_comb begin
    set_vec_s = {N_SLOTS{1'b0}};
    clr_vec_s = {N_SLOTS{1'b0}};
    if (cdb_valid && cdb_exception) begin
      set_vec_s = SLOT_ONE << cdb_id_s[N_ROB_W-1:0];
    end else begin
      set_vec_s = {N_SLOTS{1'b0}};
    end
    if (retire_s) begin
      clr_vec_s = SLOT_ONE << ret_slot_s;
    end else begin
      clr_vec_s = {N_SLOTS{1'b0}};
    end
  end

  // Next-state, exception tracking and output register values.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    exc_pend_d   = exc_pend_q;
    rf_we_d      = 1'b0;
    rf_float_d   = rf_float_q;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    rf_tag_d     = rf_tag_q;
    clear_d      = 1'b0;
    exc_cause_d  = exc_cause_q;
    exc_opcode_d = exc_opcode_q;

    case (state_q)
      ST_RUN: begin
        // Masking the set with ~clr makes clear win on a same-slot collision.
        exc_pend_d = (exc_pend_q | set_vec_s) & ~clr_vec_s;
        if (retire_s) begin
          rf_float_d = i_commit_data.dst_reg[REG_FLOAT_BIT];
          rf_addr_d  = i_commit_data.dst_reg;
          rf_data_d  = i_commit_data.content;
          rf_tag_d   = i_commit_data.station_id;
          if (pend_hit_s) begin
            // Faulting entry: tag still goes out so the busy bit is released.
            rf_we_d      = 1'b0;
            clear_d      = 1'b1;
            exc_cause_d  = i_commit_data.content;
            exc_opcode_d = i_commit_data.opcode;
            exc_pend_d   = {N_SLOTS{1'b0}};
            fcnt_d       = FLUSH_LOAD;
            state_d      = ST_FLUSH;
          end else begin
            // Integer x0 is hardwired; float f0 is an ordinary register.
            rf_we_d = (i_commit_data.dst_reg != {REG_ADDR_W{1'b0}}) ||
                      i_commit_data.dst_reg[REG_FLOAT_BIT];
          end
        end else begin
          rf_we_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        exc_pend_d = {N_SLOTS{1'b0}};
        fcnt_d     = fcnt_q - 4'd1;
        if (fcnt_q == 4'd1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d    = ST_RUN;
        fcnt_d     = 4'd0;
        exc_pend_d = {N_SLOTS{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_RUN;
      fcnt_q       <= 4'd0;
      exc_pend_q   <= {N_SLOTS{1'b0}};
      rf_we_q      <= 1'b0;
      rf_float_q   <= 1'b0;
      rf_addr_q    <= {REG_ADDR_W{1'b0}};
      rf_data_q    <= {DATA_W{1'b0}};
      rf_tag_q     <= {N_STATIONS_W{1'b0}};
      clear_q      <= 1'b0;
      exc_cause_q  <= {DATA_W{1'b0}};
      exc_opcode_q <= {INSTR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      exc_pend_q   <= exc_pend_d;
      rf_we_q      <= rf_we_d;
      rf_float_q   <= rf_float_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      rf_tag_q     <= rf_tag_d;
      clear_q      <= clear_d;
      exc_cause_q  <= exc_cause_d;
      exc_opcode_q <= exc_opcode_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_float   = rf_float_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign rf_tag     = rf_tag_q;
  assign clear      = clear_q;
  assign exc_cause  = exc_cause_q;
  assign exc_opcode = exc_opcode_q;

`ifdef COMMIT_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  // Counter increments; an exception retire counts as a retire and a flush.
  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_flushes_d = perf_flushes_q;
    if (retire_s) begin
      perf_retired_d = perf_retired_q + 32'd1;
    end else begin
      perf_retired_d = perf_retired_q;
    end
    if (clear_d) begin
      perf_flushes_d = perf_flushes_q + 16'd1;
    end else begin
      perf_flushes_d = perf_flushes_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_retired_q <= 32'd0;
      perf_flushes_q <= 16'd0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_retired = 32'd0;
  assign perf_flushes = 16'd0;
`endif

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage fed by the reorder buffer's commit port. Each cycle it accepts at most one completed head entry (`station_t`) through a valid/ready handshake. It writes the result to the integer or float architectural register file and returns the entry's tag so the register-status table can release a matching busy bit. Exceptions reported on the CDB are tracked per ROB slot; retiring a faulting entry suppresses its write, pulses `clear` to the ROB and front end, and enters a fixed-length flush.

## Interface
- `FLUSH_CYCLES`, default 4: cycles spent in FLUSH after an exception retire; legal range 1..15.
- `REG_FLOAT_BIT`, default `REG_ADDR_W-1`: bit of `dst_reg` that selects the float file (1 = float).

Ports:
- `clk` in 1: the single clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: ROB head is valid and ready.
- `i_commit_data` in `station_t`: head entry, using fields `station_id`, `dst_reg`, `opcode` and `content`.
- `i_ready` out 1: commit unit accepts this cycle.
- `cdb_valid` in 1: CDB broadcast is present.
- `cdb_exception` in 1: the broadcast result faulted.
- `cdb` in `CDB_W`: `{rsv_id[RSV_ID_W], data[DATA_W]}`; the id is at `cdb[DATA_W+:RSV_ID_W]`.
- `rf_we` out 1: architectural register write strobe.
- `rf_float` out 1: 1 targets the float file.
- `rf_addr` out `REG_ADDR_W`: destination register.
- `rf_data` out `DATA_W`: write data (`content`).
- `rf_tag` out `N_STATIONS_W`: `station_id` of the retiring entry; the status table releases the busy bit only if its stored tag equals this.
- `clear` out 1: one-cycle flush pulse to the ROB, reservation stations and fetch.
- `exc_cause` out `DATA_W`: `content` of the faulting entry; held until the next exception.
- `exc_opcode` out `INSTR_W`: `opcode` of the faulting entry; held until the next exception.
- `perf_retired` out 32: retire counter (see Configuration).
- `perf_flushes` out 16: flush counter (see Configuration).

## Operation
- States:
  - RUN (reset state).
  - FLUSH: a down-counter `fcnt` of 4 bits is loaded with `FLUSH_CYCLES`.
- `i_ready` equals 1 exactly when the state is RUN.
- A handshake (`i_valid && i_ready`) retires the entry.
- Exception vector `exc_pend[2**N_ROB_W]`:
  - Set bit `id` on `cdb_valid && cdb_exception`, where `id = cdb[DATA_W+:RSV_ID_W]`.
  - Clear bit `i_commit_data.station_id[N_ROB_W-1:0]` on retire.
  - Set on a different id and clear in the same cycle both apply.
  - Set and clear on the same id in the same cycle: clear wins.
- Normal retire (pending bit = 0):
  - Next cycle: `rf_we` = 1 if `dst_reg != 0` or the float bit is set; float `f0` is writable and integer `x0` is never written.
  - Next cycle: `rf_addr`, `rf_data`, `rf_tag` and `rf_float` are registered from the entry.
- Exception retire (pending bit = 1):
  - No register write: `rf_we` = 0, but `rf_tag` is still presented with the write suppressed.
  - Next cycle: `clear` = 1 for exactly one cycle, and `exc_cause`/`exc_opcode` are latched.
  - The state goes to FLUSH and `exc_pend` is zeroed.
- FLUSH:
  - CDB exceptions are ignored and `exc_pend` stays zero.
  - `fcnt` decrements each cycle; the state returns to RUN the cycle after `fcnt` reaches 1.
- `nrst` low, at any time including mid-FLUSH: all of the following go to 0 asynchronously — state = RUN, `exc_pend`, all outputs, and the counters. `i_ready` = 1 after reset release.

## Timing
- Retire-to-write latency is 1 cycle; throughput is 1 retire per cycle in RUN.
- Exception retire in cycle N gives:
  - `clear` high in N+1 only.
  - `i_ready` low from N+1 through N+`FLUSH_CYCLES`.
  - `i_ready` high again in N+`FLUSH_CYCLES`+1.
- A CDB exception in cycle N is visible to a retire from cycle N+1 onward. The ROB cannot present that entry as ready before N+1, so no bypass is needed.
- `rf_*` and `clear` are registered outputs; there are no combinational paths from `i_*` or `cdb*` to them.
- `i_ready` depends only on state, so there is no combinational path from `i_valid`.

## Configuration
- `COMMIT_PERF_EN` defined:
  - `perf_retired` increments on every retire, including exception retires, and wraps at 2^32.
  - `perf_flushes` increments on every `clear` pulse and wraps at 2^16.
- `COMMIT_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are instantiated.

## Test plan
- Reset: hold `nrst` = 0 for 3 cycles mid-stream → all outputs 0; `i_ready` = 1 on the first cycle after release.
- Back-to-back int and float retires: ids 0..3, `dst_reg` 5, float-5, 0, 7, with data `0xA0..0xA3` → `rf_we` pulses 1,1,0,1 on consecutive cycles with matching addr/data/tag; id 2 (`x0`) is not written.
- Exception flush: CDB exception on id 2, then retire ids 1, 2 and 3 offered with `FLUSH_CYCLES`=4 →
  - id 1 is written.
  - id 2 gives no write, `clear` for 1 cycle, and `exc_cause` = id 2 `content`.
  - `i_ready` is low for 4 cycles, then id 3 retires.
- Flush isolation: a CDB exception on id 5 arrives during FLUSH; then id 5 retires normally after RUN resumes → write occurs, no `clear`.
- Wrap-around: 2**N_ROB_W+3 retires with an exception on slot 1 of the second lap only → exactly one `clear`; `perf_retired` = 2**N_ROB_W+3 and `perf_flushes` = 1 with `COMMIT_PERF_EN` defined, both 0 without it.
- Reset mid-FLUSH: assert `nrst` at the second FLUSH cycle → state is RUN and `i_ready` = 1 after release, with no residual `clear`.
